// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with two prioritised write ports and a scoreboard.
// Optional feature macro REGFILE_BYPASS_EN forwards same-cycle write data and pending state to reads.
module register_file_mp #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_RD-1:0]              rd_enable,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
   output logic [NUM_RD-1:0]              rd_pending,
   input  logic                           wr0_enable,
   input  logic [ADDR_WIDTH-1:0]          wr0_addr,
   input  logic [DATA_WIDTH-1:0]          wr0_data,
   input  logic                           wr1_enable,
   input  logic [ADDR_WIDTH-1:0]          wr1_addr,
   input  logic [DATA_WIDTH-1:0]          wr1_data,
   input  logic                           rsv_enable,
   input  logic [ADDR_WIDTH-1:0]          rsv_addr,
   output logic                           rsv_conflict,
   output logic [DEPTH-1:0]               pending
);

   logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
   logic [DEPTH-1:0]                  pend_q, pend_d;
   logic [NUM_RD-1:0][ADDR_WIDTH-1:0] ra;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdat_q, rdat_d;
   logic [NUM_RD-1:0]                 rpend_q, rpend_d;
   logic                              conf_q, conf_d;
   logic                              wr0_ok, wr1_ok, rsv_ok;

   function automatic logic is_r0(input logic [ADDR_WIDTH-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign ra     = rd_addr;
   assign wr0_ok = wr0_enable && !is_r0(wr0_addr);
   assign wr1_ok = wr1_enable && !is_r0(wr1_addr);
   assign rsv_ok = rsv_enable && !is_r0(rsv_addr);

   // wr1 is applied last so it wins a shared address; a reserve beats a write
   always_comb begin : next_state
      regs_d = regs_q;
      pend_d = pend_q;
      if (wr0_ok) begin
         regs_d[wr0_addr] = wr0_data;
         pend_d[wr0_addr] = 1'b0;
      end
      if (wr1_ok) begin
         regs_d[wr1_addr] = wr1_data;
         pend_d[wr1_addr] = 1'b0;
      end
      if (rsv_ok) begin
         pend_d[rsv_addr] = 1'b1;
      end
      conf_d = rsv_ok && pend_q[rsv_addr];
   end

   always_comb begin : read_ports
      rdat_d  = rdat_q;
      rpend_d = rpend_q;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_enable[i]) begin
            if (is_r0(ra[i])) begin
               rdat_d[i]  = '0;
               rpend_d[i] = 1'b0;
            end else begin
`ifdef REGFILE_BYPASS_EN
               rdat_d[i]  = regs_d[ra[i]];
               rpend_d[i] = pend_d[ra[i]];
`else
               rdat_d[i]  = regs_q[ra[i]];
               rpend_d[i] = pend_q[ra[i]];
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q  <= '0;
         pend_q  <= '0;
         rdat_q  <= '0;
         rpend_q <= '0;
         conf_q  <= 1'b0;
      end else begin
         regs_q  <= regs_d;
         pend_q  <= pend_d;
         rdat_q  <= rdat_d;
         rpend_q <= rpend_d;
         conf_q  <= conf_d;
      end
   end

   assign rd_data      = rdat_q;
   assign rd_pending   = rpend_q;
   assign rsv_conflict = conf_q;
   assign pending      = pend_q;

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the 8x8, 2-read/1-write register file.
- Configurable width, depth and read-port count; two write ports with fixed priority.
- Registered reads, optional hardwired-zero register r0.
- Per-register pending (scoreboard) bits so the issue stage can stall on registers whose producer has not yet written back.

Parameters:
- DATA_WIDTH, 8, bits per register.
- DEPTH, 8, number of registers; power of two, >= 2.
- ADDR_WIDTH, $clog2(DEPTH), register address width; derived, do not override.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 0:
  - 1: r0 always reads 0; writes and reserves to r0 are ignored.
  - 0: r0 is an ordinary register.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_enable  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_pending  out  NUM_RD  registered pending bit of the register read on port i
- wr0_enable  in  1  write port 0 strobe
- wr0_addr  in  ADDR_WIDTH  write port 0 address
- wr0_data  in  DATA_WIDTH  write port 0 data
- wr1_enable  in  1  write port 1 strobe; wins over port 0 on the same address
- wr1_addr  in  ADDR_WIDTH  write port 1 address
- wr1_data  in  DATA_WIDTH  write port 1 data
- rsv_enable  in  1  reserve strobe; marks a register as pending
- rsv_addr  in  ADDR_WIDTH  register to reserve
- rsv_conflict  out  1  one-cycle pulse: reserve hit an already-pending register
- pending  out  DEPTH  live scoreboard, bit n = register n pending

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers, rd_data, rd_pending, pending and rsv_conflict clear to 0.
  - Reset asserted mid-operation discards any in-flight write or reserve.
  - First update occurs on the first rising edge after reset_n rises.
- Writes:
  - Take effect at the rising edge when the port's enable is high.
  - wr0 and wr1 to different addresses: both commit in the same cycle.
  - Same address: wr1_data is stored.
- Reads:
  - One-cycle latency: with rd_enable[i] high at edge k, rd_data[i] and rd_pending[i] reflect the addressed register from edge k onward.
  - rd_enable[i] low: rd_data[i] and rd_pending[i] hold their previous values.
  - Ports are independent; all ports may address the same register.
- Read and write to the same address in the same cycle: old value returned (read-before-write), unless REGFILE_BYPASS_EN is defined.
- Scoreboard:
  - rsv_enable sets pending[rsv_addr] at the edge.
  - A write to register n clears pending[n] at the edge.
  - Reserve and write to the same register in the same cycle: data is written and pending stays 1 (new producer overrides the old one).
  - Reserve of a register already pending: pending stays 1 and rsv_conflict is high for exactly the following cycle; otherwise rsv_conflict is 0.
  - A write to a non-pending register is legal and leaves pending at 0.
- ZERO_REG=1:
  - Reads of r0 return 0 with rd_pending 0.
  - pending[0] is constant 0; writes and reserves to r0 have no effect and never raise rsv_conflict.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read that coincides with a write to the same address returns the write data, with wr1 priority over wr0.
  - rd_pending returns the post-edge pending value, i.e. cleared by the write unless a reserve to the same register occurs in that cycle.
  - With ZERO_REG=1, r0 is never bypassed.
- Undefined: read-before-write; the pre-edge data and pending values are returned.

Test Plan:
- Defaults; write r0..r7 with 42..49 via wr0, one per cycle; then read r(i) on both ports -> both rd_data equal 42+i one cycle after each read strobe.
- Same cycle: wr0 r3=10 and wr1 r3=20; read r3 next cycle -> 20. Same cycle: wr0 r1=5 and wr1 r2=6 -> r1=5, r2=6.
- Read r7 while writing r7=99, prior value 49:
  - Without REGFILE_BYPASS_EN -> rd_data 49, then 99 on a re-read next cycle.
  - With REGFILE_BYPASS_EN -> 99 immediately.
- Scoreboard sequence:
  - Reserve r5 -> pending=8'h20.
  - Reserve r5 again -> rsv_conflict pulses 1 for one cycle.
  - Write r5=7 -> pending=0.
  - Reserve and write r2 in the same cycle -> pending[2]=1, r2 updated.
- ZERO_REG=1:
  - Write r0=55 and reserve r0 -> r0 reads 0, pending[0]=0, rsv_conflict=0.
- Reset mid-run:
  - After filling registers and reserving r4, pulse reset_n low for 3 ns between edges -> rd_data, pending, rsv_conflict are 0 immediately (asynchronous); all registers read 0 afterwards.
